// File: rtl/key_expansion_seq_if.sv
// Handshake and round-key bus between the key schedule and the decipher datapath.
interface key_expansion_seq_if #(
  parameter int unsigned x = 0
);
  localparam int unsigned KEY_W   = 128 + 64*x;
  localparam int unsigned WORDS_W = 128*(2*x + 11);

  logic               start;
  logic [0:KEY_W-1]   key;
  logic               busy;
  logic               done;
  logic               words_valid;
  logic [0:WORDS_W-1] words;

  modport master (output start, key, input busy, done, words_valid, words);
  modport slave  (input start, key, output busy, done, words_valid, words);
endinterface

// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule, one 32-bit word per clock into the round-key bus.
// Optional KEY_EXP_ZEROIZE_EN clears the non-key words when a new expansion starts.
module key_expansion_seq #(
  parameter int unsigned x = 0
) (
  input  logic              clk,
  input  logic              rst,
  key_expansion_seq_if.slave bus
);
  localparam int unsigned NK = 4 + 2*x;
  localparam int unsigned NR = 10 + 2*x;
  localparam int unsigned NW = 4*(NR + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [0:32*NW-1] words_q;
  logic [31:0]      win [NK];
  logic [5:0]       idx;
  logic [2:0]       phase;
  logic [7:0]       rcon;
  logic             done_q;
  logic             valid_q;
  logic             accept;
  logic             last;
  logic [31:0]      sb_in;
  logic [31:0]      sb_out;
  logic [31:0]      temp;
  logic [31:0]      w_new;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a4, a8, a16, a32, a64, a128, inv;
    a2   = gf_mul(a, a);
    a4   = gf_mul(a2, a2);
    a8   = gf_mul(a4, a4);
    a16  = gf_mul(a8, a8);
    a32  = gf_mul(a16, a16);
    a64  = gf_mul(a32, a32);
    a128 = gf_mul(a64, a64);
    inv  = gf_mul(gf_mul(gf_mul(a2, a4), gf_mul(a8, a16)), gf_mul(gf_mul(a32, a64), a128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (idx == 6'(NW - 1)) begin
        last     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A single SubWord serves both the RotWord and the SubWord-only step; all feedback is from the window.
  always_comb begin
    sb_in = (phase == 3'd0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
    for (int unsigned b = 0; b < 4; b++) sb_out[8*b +: 8] = sbox(sb_in[8*b +: 8]);
    if (phase == 3'd0)                    temp = sb_out ^ {rcon, 24'h0};
    else if (NK == 8 && phase == 3'd4)    temp = sb_out;
    else                                  temp = win[NK-1];
    w_new = win[0] ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      for (int unsigned j = 0; j < NK; j++) win[j] <= '0;
      idx     <= '0;
      phase   <= '0;
      rcon    <= 8'h01;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        words_q[0 +: 32*NK] <= bus.key;
`ifdef KEY_EXP_ZEROIZE_EN
        words_q[32*NK +: 32*(NW-NK)] <= '0;
`endif
        for (int unsigned j = 0; j < NK; j++) win[j] <= bus.key[32*j +: 32];
        idx     <= 6'(NK);
        phase   <= '0;
        rcon    <= 8'h01;
        valid_q <= 1'b0;
      end else if (state == RUN) begin
        words_q[32*idx +: 32] <= w_new;
        for (int unsigned j = 0; j + 1 < NK; j++) win[j] <= win[j+1];
        win[NK-1] <= w_new;
        idx       <= idx + 6'd1;
        phase     <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
        if (last) begin
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = done_q;
  assign bus.words_valid = valid_q;
  assign bus.words       = words_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: one instance per key size, checked against a FIPS-197 table model.
module tb_key_expansion_seq;
  typedef logic [31:0] sched_t [60];
  typedef struct {
    int          xs;
    logic [0:255] key;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]   st = '0;
  logic [0:255] kin [3];
  logic [2:0]   busy_v, done_v, valid_v;
  logic [31:0]  w_obs [3][60];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_expansion_seq_if #(.x(0)) if0 ();
  key_expansion_seq_if #(.x(1)) if1 ();
  key_expansion_seq_if #(.x(2)) if2 ();

  key_expansion_seq #(.x(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  key_expansion_seq #(.x(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  key_expansion_seq #(.x(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if0.key   = kin[0][0:127];
  assign if1.key   = kin[1][0:191];
  assign if2.key   = kin[2];
  assign busy_v    = {if2.busy, if1.busy, if0.busy};
  assign done_v    = {if2.done, if1.done, if0.done};
  assign valid_v   = {if2.words_valid, if1.words_valid, if0.words_valid};

  always_comb begin
    for (int i = 0; i < 60; i++) begin
      w_obs[0][i] = '0;
      w_obs[1][i] = '0;
      w_obs[2][i] = '0;
    end
    for (int i = 0; i < 44; i++) w_obs[0][i] = if0.words[32*i +: 32];
    for (int i = 0; i < 52; i++) w_obs[1][i] = if1.words[32*i +: 32];
    for (int i = 0; i < 60; i++) w_obs[2][i] = if2.words[32*i +: 32];
  end

  logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  logic [7:0] RCON [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
  endfunction

  function automatic void expand(input int xs, input logic [0:255] k, output sched_t w);
    int nk, nw;
    logic [31:0] t;
    nk = 4 + 2*xs;
    nw = 4*(11 + 2*xs);
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0)                t = subw({t[23:0], t[31:24]}) ^ {RCON[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
  endfunction

  function automatic int lat_of(input int xs);
    return 40 + 6*xs;
  endfunction

  function automatic int nw_of(input int xs);
    return 44 + 8*xs;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input int sel, input logic [0:255] k);
    kin[sel] = k;
    st[sel]  = 1'b1;
    @(negedge clk);
    st[sel]  = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge; returns at the done negedge.
  task automatic track(input int sel, input int p1, input int p2, input logic [0:255] junk,
                       output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      st[sel] = (k == p1 || k == p2);
      if (k == p1 || k == p2) kin[sel] = junk;
      if (busy_v[sel]) bc++;
      if (done_v[sel]) begin
        lat     = k;
        st[sel] = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_run(input int sel, input logic [0:255] k, input int lat, input int bc);
    sched_t e;
    expand(sel, k, e);
    chk($sformatf("x%0d latency", sel), 32'(lat), 32'(lat_of(sel)));
    chk($sformatf("x%0d busy cycles", sel), 32'(bc), 32'(lat_of(sel)));
    chk($sformatf("x%0d valid at done", sel), 32'(valid_v[sel]), 32'd1);
    chk($sformatf("x%0d busy at done", sel), 32'(busy_v[sel]), 32'd0);
    for (int i = 0; i < nw_of(sel); i++)
      chk($sformatf("x%0d w[%0d]", sel, i), w_obs[sel][i], e[i]);
  endtask

  task automatic run_full(input int sel, input logic [0:255] k);
    int lat, bc;
    @(negedge clk);
    launch(sel, k);
    track(sel, -1, -1, '0, lat, bc);
    check_run(sel, k, lat, bc);
    @(negedge clk);
    chk($sformatf("x%0d done width", sel), 32'(done_v[sel]), 32'd0);
    chk($sformatf("x%0d valid held", sel), 32'(valid_v[sel]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:255] K1, K2, K3, kr, k2;
    vec_t   vecs [7];
    sched_t prev, cur;
    int     lat, bc, dc, xs;
    logic [31:0] ez;

    K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    vecs[0] = '{0, K1, 4,  32'ha0fafe17};
    vecs[1] = '{0, K1, 43, 32'hb6630ca6};
    vecs[2] = '{1, K2, 6,  32'hfe0c91f7};
    vecs[3] = '{1, K2, 51, 32'h01002202};
    vecs[4] = '{2, K3, 8,  32'h9ba35411};
    vecs[5] = '{2, K3, 12, 32'ha8b09c1a};
    vecs[6] = '{2, K3, 59, 32'h706c631e};
    for (int s = 0; s < 3; s++) kin[s] = '0;

    // reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("x%0d reset busy", s), 32'(busy_v[s]), 32'd0);
      chk($sformatf("x%0d reset done", s), 32'(done_v[s]), 32'd0);
      chk($sformatf("x%0d reset valid", s), 32'(valid_v[s]), 32'd0);
      for (int i = 0; i < nw_of(s); i++)
        chk($sformatf("x%0d reset w[%0d]", s, i), w_obs[s][i], 32'h0);
    end
    rst = 1'b0;

    // FIPS-197 table
    for (int v = 0; v < 7; v++) begin
      run_full(vecs[v].xs, vecs[v].key);
      chk($sformatf("fips x%0d w[%0d]", vecs[v].xs, vecs[v].idx), w_obs[vecs[v].xs][vecs[v].idx], vecs[v].exp);
    end

    // random keys against the model
    for (int r = 0; r < 6; r++) begin
      xs = int'($urandom_range(0, 2));
      for (int q = 0; q < 8; q++) kr[32*q +: 32] = $urandom();
      run_full(xs, kr);
    end

    // reset mid-expansion
    @(negedge clk);
    launch(0, K1);
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_v[0]) dc++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy_v[0]), 32'd0);
    chk("abort valid", 32'(valid_v[0]), 32'd0);
    for (int i = 0; i < 44; i++) chk($sformatf("abort w[%0d]", i), w_obs[0][i], 32'h0);
    for (int k = 0; k < 45; k++) begin
      if (done_v[0]) dc++;
      @(negedge clk);
    end
    chk("abort no done", 32'(dc), 32'd0);
    run_full(0, K1);

    // ignored starts mid-run, then back-to-back restart on the done cycle
    for (int q = 0; q < 8; q++) kr[32*q +: 32] = $urandom();
    for (int q = 0; q < 8; q++) k2[32*q +: 32] = $urandom();
    @(negedge clk);
    launch(0, K1);
    track(0, 5, 30, kr, lat, bc);
    check_run(0, K1, lat, bc);
    launch(0, k2);
    chk("b2b valid drop", 32'(valid_v[0]), 32'd0);
    chk("b2b busy", 32'(busy_v[0]), 32'd1);
    track(0, -1, -1, '0, lat, bc);
    check_run(0, k2, lat, bc);

    // restart content of unwritten words
    for (int q = 0; q < 8; q++) kr[32*q +: 32] = $urandom();
    run_full(2, kr);
    expand(2, kr, prev);
    expand(2, K3, cur);
    @(negedge clk);
    launch(2, K3);
    for (int i = 0; i < 8; i++) chk($sformatf("restart key w[%0d]", i), w_obs[2][i], cur[i]);
    for (int i = 8; i < 60; i++) begin
`ifdef KEY_EXP_ZEROIZE_EN
      ez = 32'h0;
`else
      ez = prev[i];
`endif
      chk($sformatf("restart stale w[%0d]", i), w_obs[2][i], ez);
    end
    track(2, -1, -1, '0, lat, bc);
    check_run(2, K3, lat, bc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
